// File: rtl/to_serial_stream.sv
// to_serial_stream: multi-channel parallel-to-serial converter.
// Each accepted word (NO_CH channels of BW_IN bits) is emitted as NO_CYC
// slices of BW_OUT bits per channel, all channels in lockstep. A one-word
// holding buffer lets back-to-back words stream out without a bubble.
// Words are zero-padded to NO_CYC*BW_OUT bits so padding lands in the last slice.
module to_serial_stream #(
  parameter int NO_CH     = 10,
  parameter int BW_IN     = 8,
  parameter int BW_OUT    = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           vld_in,
  output logic                           rdy_in,
  input  logic [NO_CH-1:0][BW_IN-1:0]    data_in,
  output logic                           vld_out,
  input  logic                           rdy_out,
  output logic [NO_CH-1:0][BW_OUT-1:0]   data_out,
  output logic                           first_out,
  output logic                           last_out
);

  localparam int NO_CYC = (BW_IN + BW_OUT - 1) / BW_OUT;
  localparam int PW     = NO_CYC * BW_OUT;
  localparam int CW     = (NO_CYC > 1) ? $clog2(NO_CYC) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NO_CYC - 1);

  typedef logic [NO_CH-1:0][PW-1:0]    shift_t;
  typedef logic [NO_CH-1:0][BW_IN-1:0] word_t;

  // Place each channel word so that the padding zeros end up in the final slice.
  function automatic shift_t pad_word(input word_t w);
    shift_t p;
    p = '0;
    for (int c = 0; c < NO_CH; c++) begin
      if (MSB_FIRST) p[c][PW-1 -: BW_IN] = w[c];
      else           p[c][BW_IN-1:0]     = w[c];
    end
    return p;
  endfunction

  // Move the next slice into the output end of each channel's shift register.
  function automatic shift_t advance(input shift_t s);
    shift_t r;
    r = '0;
    for (int c = 0; c < NO_CH; c++) begin
      if (MSB_FIRST) r[c] = s[c] << BW_OUT;
      else           r[c] = s[c] >> BW_OUT;
    end
    return r;
  endfunction

  logic            active, active_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            hold_vld, hold_vld_n;
  word_t           hold_data, hold_data_n;
  shift_t          sh, sh_n;
  logic            accept, slice_hs;

  assign accept   = vld_in && rdy_in;
  assign slice_hs = active && rdy_out;

  // Next-state: advance on a slice handshake, refill from hold or input at word end.
  always_comb begin
    active_n    = active;
    cnt_n       = cnt;
    hold_vld_n  = hold_vld;
    hold_data_n = hold_data;
    sh_n        = sh;
    if (slice_hs && (cnt == LAST_CNT)) begin
      cnt_n = '0;
      if (hold_vld) begin
        sh_n       = pad_word(hold_data);
        hold_vld_n = 1'b0;
      end else if (accept) begin
        sh_n = pad_word(data_in);
      end else begin
        active_n = 1'b0;
      end
    end else begin
      if (slice_hs) begin
        sh_n  = advance(sh);
        cnt_n = cnt + CW'(1);
      end
      if (accept) begin
        if (!active) begin
          sh_n     = pad_word(data_in);
          active_n = 1'b1;
          cnt_n    = '0;
        end else begin
          hold_data_n = data_in;
          hold_vld_n  = 1'b1;
        end
      end
    end
  end

  // State registers; rdy_in is registered from the next hold state so it stays low in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active    <= 1'b0;
      cnt       <= '0;
      hold_vld  <= 1'b0;
      hold_data <= '0;
      sh        <= '0;
      rdy_in    <= 1'b0;
    end else begin
      active    <= active_n;
      cnt       <= cnt_n;
      hold_vld  <= hold_vld_n;
      hold_data <= hold_data_n;
      sh        <= sh_n;
      rdy_in    <= !hold_vld_n;
    end
  end

  // Present the slice sitting at the output end of each shift register.
  always_comb begin
    data_out = '0;
    for (int c = 0; c < NO_CH; c++) begin
      if (MSB_FIRST) data_out[c] = sh[c][PW-1 -: BW_OUT];
      else           data_out[c] = sh[c][BW_OUT-1:0];
    end
  end

  assign vld_out   = active;
  assign first_out = active && (cnt == '0);
  assign last_out  = active && (cnt == LAST_CNT);

endmodule
